// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// lsu_ctrl_if : request/response and data-memory bundle for lsu_ctrl
// Rev 1.0
// ============================================================================
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_w_enable;
    logic [1:0]  mem_access_size;
    logic        mem_RdUn;
    logic [31:0] mem_data_out;

    // master: execute stage plus data memory; slave: the controller
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_address, mem_data_in, mem_w_enable, mem_access_size, mem_RdUn
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_address, mem_data_in, mem_w_enable, mem_access_size, mem_RdUn
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// lsu_ctrl : range/alignment-checking load/store controller for byte memory
// Optional MISALIGN_SPLIT_EN turns misaligned accesses into byte sequences.
// Rev 1.0
// ============================================================================
module lsu_ctrl #(
    parameter logic [31:0] START_ADDRESS = 32'h0100_0000,
    parameter logic [31:0] MEM_SIZE      = 32'd1048576
) (
    input wire        clk,
    input wire        rst_n,
    lsu_ctrl_if.slave bus
);

    localparam logic [32:0] c_LAST_ADDR = {1'b0, START_ADDRESS} + {1'b0, MEM_SIZE} - 33'd1;

`ifdef MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_SPLIT = 2'd2, S_RESP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_RESP = 2'd3} state_t;
`endif

    state_t      state_q;
    logic        req_ready_q;
    logic        we_q;
    logic        resp_valid_q;
    logic        resp_fault_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_data_in_q;
    logic        mem_w_enable_q;
    logic [1:0]  mem_access_size_q;
    logic        mem_RdUn_q;

    logic [2:0]  w_nbytes;
    logic [32:0] w_end_addr;
    logic        w_range_flt;
    logic        w_misalign;
    logic        w_fault;

    // End address is formed in 33 bits so a request near 2^32 cannot wrap into range
    always_comb begin
        case (bus.req_size)
            2'b00:   w_nbytes = 3'd1;
            2'b01:   w_nbytes = 3'd2;
            default: w_nbytes = 3'd4;
        endcase
        w_end_addr  = {1'b0, bus.req_addr} + {30'd0, w_nbytes} - 33'd1;
        w_range_flt = ({1'b0, bus.req_addr} < {1'b0, START_ADDRESS}) || (w_end_addr > c_LAST_ADDR);
        w_misalign  = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`ifdef MISALIGN_SPLIT_EN
        w_fault     = w_range_flt || (bus.req_size == 2'b11);
`else
        w_fault     = w_range_flt || (bus.req_size == 2'b11) || w_misalign;
`endif
    end

`ifdef MISALIGN_SPLIT_EN
    logic [1:0]  idx_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic        w_last;
    logic [31:0] w_merge;
    logic [31:0] w_ext;

    always_comb begin
        w_last  = (size_q == 2'b01) ? (idx_q == 2'd1) : (idx_q == 2'd3);
        w_merge = resp_rdata_q;
        w_merge[{idx_q, 3'b000} +: 8] = bus.mem_data_out[7:0];
        if (size_q == 2'b01) begin
            w_ext = uns_q ? {16'h0000, w_merge[15:0]} : {{16{w_merge[15]}}, w_merge[15:0]};
        end else begin
            w_ext = w_merge;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            req_ready_q       <= 1'b1;
            we_q              <= 1'b0;
            resp_valid_q      <= 1'b0;
            resp_fault_q      <= 1'b0;
            resp_rdata_q      <= 32'd0;
            mem_address_q     <= 32'd0;
            mem_data_in_q     <= 32'd0;
            mem_w_enable_q    <= 1'b0;
            mem_access_size_q <= 2'b10;
            mem_RdUn_q        <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            idx_q             <= 2'd0;
            size_q            <= 2'b10;
            uns_q             <= 1'b0;
            wdata_q           <= 32'd0;
`endif
        end else begin
            // Memory port falls back to its idle values unless a state drives it
            resp_valid_q      <= 1'b0;
            mem_address_q     <= 32'd0;
            mem_data_in_q     <= 32'd0;
            mem_w_enable_q    <= 1'b0;
            mem_access_size_q <= 2'b10;
            mem_RdUn_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_q  <= 1'b0;
                        we_q         <= bus.req_we;
                        resp_rdata_q <= 32'd0;
                        resp_fault_q <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
                        idx_q        <= 2'd0;
                        size_q       <= bus.req_size;
                        uns_q        <= bus.req_unsigned;
                        wdata_q      <= {8'h00, bus.req_wdata[31:8]};
`endif
                        if (w_fault) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
`ifdef MISALIGN_SPLIT_EN
                        end else if (w_misalign) begin
                            state_q           <= S_SPLIT;
                            mem_address_q     <= bus.req_addr;
                            mem_data_in_q     <= {24'h000000, bus.req_wdata[7:0]};
                            mem_w_enable_q    <= bus.req_we;
                            mem_access_size_q <= 2'b00;
                            mem_RdUn_q        <= 1'b1;
`endif
                        end else begin
                            state_q           <= S_ACC;
                            mem_address_q     <= bus.req_addr;
                            mem_data_in_q     <= bus.req_wdata;
                            mem_w_enable_q    <= bus.req_we;
                            mem_access_size_q <= bus.req_size;
                            mem_RdUn_q        <= bus.req_unsigned;
                        end
                    end
                end
                S_ACC: begin
                    if (!we_q) begin
                        resp_rdata_q <= bus.mem_data_out;
                    end
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                end
`ifdef MISALIGN_SPLIT_EN
                S_SPLIT: begin
                    if (!we_q) begin
                        resp_rdata_q <= w_last ? w_ext : w_merge;
                    end
                    if (w_last) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                    end else begin
                        // Store bytes are shifted out of wdata_q, lowest first
                        idx_q             <= idx_q + 2'd1;
                        mem_address_q     <= mem_address_q + 32'd1;
                        mem_data_in_q     <= {24'h000000, wdata_q[7:0]};
                        wdata_q           <= {8'h00, wdata_q[31:8]};
                        mem_w_enable_q    <= we_q;
                        mem_access_size_q <= 2'b00;
                        mem_RdUn_q        <= 1'b1;
                    end
                end
`endif
                S_RESP: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.resp_fault      = resp_fault_q;
    assign bus.mem_address     = mem_address_q;
    assign bus.mem_data_in     = mem_data_in_q;
    assign bus.mem_w_enable    = mem_w_enable_q;
    assign bus.mem_access_size = mem_access_size_q;
    assign bus.mem_RdUn        = mem_RdUn_q;

endmodule
`default_nettype wire
